// File: rtl/program_loader.sv
// ============================================================================
// program_loader
// ----------------------------------------------------------------------------
// Receives a length-prefixed byte stream from a serial front end and writes
// the payload into memory at addresses 0,1,2,... while holding the CPU.
//
// Frame: [N] [payload x N] [sum]   (N = 0 means 256 payload bytes; the sum
// byte is present only when LOADER_CHECKSUM_EN is defined).
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   defined   : an 8-bit running sum (mod 256) of the payload is kept, a
//               trailing checksum byte is compared in CHECK, and a mismatch
//               parks the loader in ERROR (error=1, cpu_hold=1) until reset,
//               or until start re-arms a new load.
//   undefined : no CHECK/ERROR states, no sum logic, error tied to 0.
//
// Ports
//   clk          in   sole clock, rising edge
//   reset        in   synchronous active-high reset
//   start        in   one-cycle request to begin a load (IDLE/ERROR only)
//   rx_data[7:0] in   incoming byte
//   rx_valid     in   rx_data holds a byte
//   rx_ready     out  loader accepts a byte this cycle
//   mem_write    out  one-cycle write strobe
//   mem_address  out  write address (registered)
//   mem_data     out  write data (registered)
//   cpu_hold     out  holds the CPU (drives pc_reset)
//   done         out  one-cycle pulse on a successful load
//   error        out  checksum failure flag
//   dbg_state_o  out  current FSM state encoding, for checkers
//
// Handshake: a byte transfers on a rising edge where rx_valid=1 and
// rx_ready=1. rx_ready does not depend on rx_valid; rx_valid=0 simply stalls
// the receiving state with no state change.
// ============================================================================
module program_loader (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic       mem_write,
    output logic [7:0] mem_address,
    output logic [7:0] mem_data,
    output logic       cpu_hold,
    output logic       done,
    output logic       error,
    output logic [2:0] dbg_state_o
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_DONE  = 3'd4
    } state_t;
`endif

    state_t     state_q, state_d;
    logic [7:0] addr_q,  addr_d;
    logic [7:0] len_q,   len_d;
    // Set for the single cycle in which the final payload write strobe is
    // out; it keeps DATA from accepting more and delays the exit so that
    // done (or CHECK) follows the last write rather than overlapping it.
    logic       drain_q, drain_d;
    logic       wr_q,    wr_d;
    logic [7:0] wa_q,    wa_d;
    logic [7:0] wd_q,    wd_d;
    logic       ready_q, ready_d;
    logic       hold_q,  hold_d;
    logic       done_q,  done_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum_q,   sum_d;
    logic       err_q,   err_d;
`endif

    logic accept;
    assign accept = rx_valid & ready_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        drain_d = drain_q;
        wr_d    = 1'b0;
        wa_d    = wa_q;
        wd_d    = wd_q;
`ifdef LOADER_CHECKSUM_EN
        sum_d   = sum_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_LEN;
            end
            ST_LEN: begin
                if (accept) begin
                    len_d   = rx_data;
                    addr_d  = 8'd0;
                    drain_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
                    sum_d   = 8'd0;
`endif
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (drain_q) begin
                    drain_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_DONE;
`endif
                end else if (accept) begin
                    wr_d   = 1'b1;
                    wa_d   = addr_q;
                    wd_d   = rx_data;
                    // 8-bit wrap: for N=0 the last write is at 0xFF and
                    // the counter returns to 0x00 with no further write.
                    addr_d = addr_q + 8'd1;
`ifdef LOADER_CHECKSUM_EN
                    sum_d  = sum_q + rx_data;
`endif
                    // len_q - 1 wraps to 0xFF when N=0, giving 256 bytes.
                    if (addr_q == len_q - 8'd1) drain_d = 1'b1;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (accept) state_d = (rx_data == sum_q) ? ST_DONE : ST_ERROR;
            end
            ST_ERROR: begin
                if (start) state_d = ST_LEN;
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered outputs are decoded from the next state so they line
        // up with the state register.
        ready_d = (state_d == ST_LEN) || ((state_d == ST_DATA) && !drain_d);
        hold_d  = (state_d == ST_LEN) || (state_d == ST_DATA);
        done_d  = (state_d == ST_DONE);
`ifdef LOADER_CHECKSUM_EN
        ready_d = ready_d || (state_d == ST_CHECK);
        hold_d  = hold_d || (state_d == ST_CHECK) || (state_d == ST_ERROR);
        err_d   = (state_d == ST_ERROR);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= 8'd0;
            len_q   <= 8'd0;
            drain_q <= 1'b0;
            wr_q    <= 1'b0;
            wa_q    <= 8'd0;
            wd_q    <= 8'd0;
            ready_q <= 1'b0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q   <= 8'd0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            drain_q <= drain_d;
            wr_q    <= wr_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            ready_q <= ready_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
            err_q   <= err_d;
`endif
        end
    end

    assign rx_ready    = ready_q;
    assign mem_write   = wr_q;
    assign mem_address = wa_q;
    assign mem_data    = wd_q;
    assign cpu_hold    = hold_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;
`ifdef LOADER_CHECKSUM_EN
    assign error       = err_q;
`else
    assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// ============================================================================
// tb_program_loader -- directed self-checking bench for program_loader.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// there too. A monitor records every write strobe at the falling edge.
// ============================================================================
module tb_program_loader;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LEN   = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_ERROR = 3'd5;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       mem_write;
    logic [7:0] mem_address;
    logic [7:0] mem_data;
    logic       cpu_hold;
    logic       done;
    logic       error;
    logic [2:0] dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];
    int          obs_cyc_q[$];

    program_loader dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .cpu_hold    (cpu_hold),
        .done        (done),
        .error       (error),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_write === 1'b1) begin
            obs_q.push_back({mem_address, mem_data});
            obs_cyc_q.push_back(cyc);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before timeout");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Presents one byte and waits (bounded) for it to be accepted; returns
    // 1 time unit after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (rx_ready === 1'b1) ok = 1'b1;
        end
        n_cmp++;
        if (ok) begin
            @(posedge clk);
            #1;
        end else begin
            n_err++;
            $display("FAIL send_byte_accept: byte %02h never accepted, rx_ready=%b required 1", b, rx_ready);
        end
        rx_valid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        tick(); tick();
        n_cmp++; if (rx_ready !== 1'b0)    begin n_err++; $display("FAIL reset_rx_ready: got %b want 0", rx_ready); end
        n_cmp++; if (mem_write !== 1'b0)   begin n_err++; $display("FAIL reset_mem_write: got %b want 0", mem_write); end
        n_cmp++; if (mem_address !== 8'h00) begin n_err++; $display("FAIL reset_mem_address: got %02h want 00", mem_address); end
        n_cmp++; if (mem_data !== 8'h00)   begin n_err++; $display("FAIL reset_mem_data: got %02h want 00", mem_data); end
        n_cmp++; if (cpu_hold !== 1'b0)    begin n_err++; $display("FAIL reset_cpu_hold: got %b want 0", cpu_hold); end
        n_cmp++; if (done !== 1'b0)        begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (error !== 1'b0)       begin n_err++; $display("FAIL reset_error: got %b want 0", error); end
        n_cmp++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
        reset = 1'b0;
        tick();
        n_cmp++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL idle_no_start: got %0d want %0d", dbg_state, ST_IDLE); end
    endtask

    task automatic test_back_to_back();
        obs_q.delete(); obs_cyc_q.delete(); exp_q.delete();
        exp_q.push_back(16'h00AA); exp_q.push_back(16'h01BB); exp_q.push_back(16'h02CC);
        pulse_start();
        n_cmp++; if (rx_ready !== 1'b1) begin n_err++; $display("FAIL b2b_len_ready: got %b want 1", rx_ready); end
        n_cmp++; if (cpu_hold !== 1'b1) begin n_err++; $display("FAIL b2b_len_hold: got %b want 1", cpu_hold); end
        send_byte(8'h03);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        // write cycle of the last byte
        n_cmp++; if (mem_write !== 1'b1 || mem_address !== 8'h02 || mem_data !== 8'hCC) begin
            n_err++; $display("FAIL b2b_last_write: got w=%b a=%02h d=%02h want w=1 a=02 d=CC", mem_write, mem_address, mem_data); end
        n_cmp++; if (done !== 1'b0 || cpu_hold !== 1'b1) begin
            n_err++; $display("FAIL b2b_hold_during_write: got done=%b hold=%b want done=0 hold=1", done, cpu_hold); end
        tick();
        n_cmp++; if (done !== 1'b1 || cpu_hold !== 1'b0 || mem_write !== 1'b0) begin
            n_err++; $display("FAIL b2b_done_pulse: got done=%b hold=%b w=%b want done=1 hold=0 w=0", done, cpu_hold, mem_write); end
        n_cmp++; if (error !== 1'b0) begin n_err++; $display("FAIL b2b_error: got %b want 0", error); end
        tick();
        n_cmp++; if (done !== 1'b0 || dbg_state !== ST_IDLE) begin
            n_err++; $display("FAIL b2b_done_one_cycle: got done=%b state=%0d want done=0 state=%0d", done, dbg_state, ST_IDLE); end
        n_cmp++; if (obs_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL b2b_write_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++; if (obs_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL b2b_write[%0d]: got %04h want %04h", i, obs_q[i], exp_q[i]); end
        end
        for (int i = 1; i < obs_cyc_q.size(); i++) begin
            n_cmp++; if (obs_cyc_q[i] != obs_cyc_q[i-1] + 1) begin
                n_err++; $display("FAIL b2b_consecutive[%0d]: gap %0d cycles want 1", i, obs_cyc_q[i] - obs_cyc_q[i-1]); end
        end
    endtask

    task automatic test_full_256();
        obs_q.delete(); obs_cyc_q.delete(); exp_q.delete();
        pulse_start();
        send_byte(8'h00);
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back({i[7:0], i[7:0]});
            send_byte(i[7:0]);
        end
        n_cmp++; if (mem_write !== 1'b1 || mem_address !== 8'hFF || mem_data !== 8'hFF) begin
            n_err++; $display("FAIL full_last_write: got w=%b a=%02h d=%02h want w=1 a=FF d=FF", mem_write, mem_address, mem_data); end
        tick();
        n_cmp++; if (done !== 1'b1 || mem_write !== 1'b0) begin
            n_err++; $display("FAIL full_done: got done=%b w=%b want done=1 w=0", done, mem_write); end
        tick(); tick();
        n_cmp++; if (obs_q.size() != 256) begin
            n_err++; $display("FAIL full_write_count: got %0d want 256", obs_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++; if (obs_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL full_write[%0d]: got %04h want %04h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid_load();
        obs_q.delete(); obs_cyc_q.delete();
        pulse_start();
        send_byte(8'h05);
        send_byte(8'h11);
        send_byte(8'h22);
        // reset beats start and a presented byte
        reset = 1'b1; start = 1'b1; rx_valid = 1'b1; rx_data = 8'h99;
        tick();
        n_cmp++; if (mem_write !== 1'b0) begin n_err++; $display("FAIL rst_mid_write: got %b want 0", mem_write); end
        n_cmp++; if (dbg_state !== ST_IDLE || cpu_hold !== 1'b0 || rx_ready !== 1'b0) begin
            n_err++; $display("FAIL rst_mid_state: got state=%0d hold=%b ready=%b want state=0 hold=0 ready=0", dbg_state, cpu_hold, rx_ready); end
        reset = 1'b0; start = 1'b0; rx_valid = 1'b0;
        tick(); tick();
        n_cmp++; if (dbg_state !== ST_IDLE || mem_write !== 1'b0) begin
            n_err++; $display("FAIL rst_mid_after: got state=%0d w=%b want state=0 w=0", dbg_state, mem_write); end
        n_cmp++; if (obs_q.size() != 2) begin
            n_err++; $display("FAIL rst_mid_write_count: got %0d want 2", obs_q.size()); end
    endtask

    task automatic test_stall_and_start();
        obs_q.delete(); obs_cyc_q.delete(); exp_q.delete();
        exp_q.push_back(16'h0051); exp_q.push_back(16'h0152);
        exp_q.push_back(16'h0253); exp_q.push_back(16'h0354);
        pulse_start();
        send_byte(8'h04);
        send_byte(8'h51);
        rx_data = 8'hEE; start = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++; if (dbg_state !== ST_DATA || mem_write !== 1'b0) begin
            n_err++; $display("FAIL stall_1: got state=%0d w=%b want state=%0d w=0", dbg_state, mem_write, ST_DATA); end
        tick();
        n_cmp++; if (dbg_state !== ST_DATA || mem_write !== 1'b0) begin
            n_err++; $display("FAIL stall_2: got state=%0d w=%b want state=%0d w=0", dbg_state, mem_write, ST_DATA); end
        send_byte(8'h52);
        start = 1'b1;
        send_byte(8'h53);
        start = 1'b0;
        send_byte(8'h54);
        tick();
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL stall_done: got %b want 1", done); end
        tick();
        n_cmp++; if (obs_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL stall_write_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++; if (obs_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL stall_write[%0d]: got %04h want %04h", i, obs_q[i], exp_q[i]); end
        end
    endtask

`ifdef LOADER_CHECKSUM_EN
    task automatic test_checksum();
        obs_q.delete(); obs_cyc_q.delete();
        pulse_start();
        send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'h30);
        n_cmp++; if (done !== 1'b1 || error !== 1'b0) begin
            n_err++; $display("FAIL csum_good: got done=%b err=%b want done=1 err=0", done, error); end
        tick(); tick();
        n_cmp++; if (obs_q.size() != 2) begin
            n_err++; $display("FAIL csum_good_writes: got %0d want 2", obs_q.size()); end
        pulse_start();
        send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'h31);
        n_cmp++; if (error !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0) begin
            n_err++; $display("FAIL csum_bad: got err=%b hold=%b done=%b want err=1 hold=1 done=0", error, cpu_hold, done); end
        tick(); tick(); tick();
        n_cmp++; if (error !== 1'b1 || done !== 1'b0 || dbg_state !== ST_ERROR) begin
            n_err++; $display("FAIL csum_bad_sticky: got err=%b done=%b state=%0d want err=1 done=0 state=5", error, done, dbg_state); end
        pulse_start();
        n_cmp++; if (error !== 1'b0 || dbg_state !== ST_LEN) begin
            n_err++; $display("FAIL csum_restart: got err=%b state=%0d want err=0 state=1", error, dbg_state); end
        reset = 1'b1; tick(); reset = 1'b0; tick();
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_back_to_back();
        test_full_256();
        test_reset_mid_load();
        test_stall_and_start();
`ifdef LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
